// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - shared RV32I datapath types and constants
package riscv_32i_defs_pkg;

  localparam int XLEN          = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef logic [XLEN-1:0]          word_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  localparam rf_addr_t X0 = '0;

  typedef struct packed {
    rf_addr_t addr;
    word_t    data;
  } rf_wr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_port_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;

  // On contention the port that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin share of the register-file write port
module rf_wb_arbiter
  import riscv_32i_defs_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [RF_ADDR_WIDTH-1:0] req0_addr,
  input  logic [XLEN-1:0]      req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [RF_ADDR_WIDTH-1:0] req1_addr,
  input  logic [XLEN-1:0]      req1_data,
  output logic                 rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [XLEN-1:0]      rf_wr_data,
  output logic [CNT_WIDTH-1:0] contend_cnt
);

  logic       real0, real1, null0, null1;
  logic [1:0] gnt;
  wb_port_t   win_port;
  rf_wr_t     win_wr;
  rf_wr_t     wr_q;
  logic       wr_en_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Writes to X0 are sunk immediately and never touch arbitration state.
  assign real0 = req0_valid && (req0_addr != X0);
  assign real1 = req1_valid && (req1_addr != X0);
  assign null0 = req0_valid && (req0_addr == X0);
  assign null1 = req1_valid && (req1_addr == X0);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({real1, real0}),
    .advance (real0 || real1),
    .gnt     (gnt)
  );

  assign req0_ready = rst_n && (null0 || gnt[0]);
  assign req1_ready = rst_n && (null1 || gnt[1]);

  assign win_port = gnt[1] ? WB_LSU : WB_ALU;

  always_comb begin
    win_wr = '{addr: req0_addr, data: req0_data};
    if (win_port == WB_LSU) begin
      win_wr = '{addr: req1_addr, data: req1_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      wr_q    <= '{addr: X0, data: '0};
      cnt_q   <= '0;
    end else begin
      wr_en_q <= (gnt != 2'b00);
      if (gnt != 2'b00) begin
        wr_q <= win_wr;
      end
      if (real0 && real1 && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rf_wr_en    = wr_en_q;
  assign rf_wr_addr  = wr_q.addr;
  assign rf_wr_data  = wr_q.data;
  assign contend_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [15:0] contend_cnt;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .contend_cnt (contend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    #1;
    check("rst_wr_en",   rf_wr_en,    0);
    check("rst_wr_addr", rf_wr_addr,  0);
    check("rst_wr_data", rf_wr_data,  0);
    check("rst_cnt",     contend_cnt, 0);
    check("rst_ready0",  req0_ready,  0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    rst_n = 1'b1;

    // single write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("single_en",   rf_wr_en,   1);
    check("single_addr", rf_wr_addr, 5);
    check("single_data", rf_wr_data, 32'hDEADBEEF);
    step();
    check("single_en_off",  rf_wr_en,   0);
    check("single_addr_hold", rf_wr_addr, 5);

    // contention and fairness
    do_reset();
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_ready0_%0d", i), req0_ready, (i % 2 == 0));
      check($sformatf("cont_ready1_%0d", i), req1_ready, (i % 2 == 1));
      step();
      check($sformatf("cont_en_%0d", i),   rf_wr_en,   1);
      check($sformatf("cont_addr_%0d", i), rf_wr_addr, (i % 2 == 0) ? 3 : 4);
      check($sformatf("cont_data_%0d", i), rf_wr_data, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("cont_cnt", contend_cnt, 4);

    // X0 sink alongside a real write
    drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd7, 32'h55);
    #1;
    check("x0_ready0", req0_ready, 1);
    check("x0_ready1", req1_ready, 1);
    step();
    check("x0_en",   rf_wr_en,    1);
    check("x0_addr", rf_wr_addr,  7);
    check("x0_data", rf_wr_data,  32'h55);
    check("x0_cnt",  contend_cnt, 4);
    // null on port 0 alone must not move last_grant off port 1
    drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
    #1;
    check("x0_only_ready0", req0_ready, 1);
    step();
    check("x0_only_en",   rf_wr_en,   0);
    check("x0_only_addr", rf_wr_addr, 7);
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    #1;
    check("x0_lg_ready0", req0_ready, 1);
    check("x0_lg_ready1", req1_ready, 0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("x0_lg_cnt", contend_cnt, 5);

    // same-address collision right after reset
    do_reset();
    drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
    #1;
    check("coll_ready0", req0_ready, 1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB);
    check("coll_w1_addr", rf_wr_addr, 9);
    check("coll_w1_data", rf_wr_data, 32'hA);
    #1;
    check("coll_ready1", req1_ready, 1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("coll_w2_en",   rf_wr_en,   1);
    check("coll_w2_addr", rf_wr_addr, 9);
    check("coll_w2_data", rf_wr_data, 32'hB);

    // asynchronous reset with a write pending on the output
    drive(1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 32'h0);
    step();
    check("arst_pre_en", rf_wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en",     rf_wr_en,    0);
    check("arst_addr",   rf_wr_addr,  0);
    check("arst_ready0", req0_ready,  0);
    rst_n = 1'b1;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    #1;
    check("arst_post_ready0", req0_ready, 1);
    check("arst_post_ready1", req1_ready, 0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("arst_post_addr", rf_wr_addr, 1);

    // counter saturation
    do_reset();
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", contend_cnt, 16'hFFFE);
    step();
    check("sat_ffff", contend_cnt, 16'hFFFF);
    repeat (5) step();
    check("sat_hold", contend_cnt, 16'hFFFF);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
